// File: rtl/adiabatic_nor_pipe.sv
// Purpose : multi-lane NOR gate followed by an adiabatic buffer pipeline driven by a
//           four-phase power clock (WAIT -> EVAL -> HOLD -> RECOVER).
// Latency : a word captured in WAIT cycle t appears in cycle t+2+4*(STAGES-1); en=0 adds a cycle each.
// Backpressure: none; a capture happens in every enabled WAIT cycle and in_ready only marks that slot.
//
// Ports   : clk, reset (sync, active-high), en (power-clock advance), in_valid/in_data (lane i
//           inputs at [i*FANIN +: FANIN]), in_ready, phase, out_valid, out (one bit per lane).
// Build   : define ADIABATIC_RECOVERY_EN to force out to zero whenever out_valid is low;
//           otherwise out continuously shows the last-stage register.
module adiabatic_nor_pipe #(
    parameter int WIDTH  = 4,
    parameter int FANIN  = 2,
    parameter int STAGES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [WIDTH*FANIN-1:0] in_data,
    output logic                   in_ready,
    output logic [1:0]             phase,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out
);

    typedef enum logic [1:0] {
        PH_WAIT    = 2'd0,
        PH_EVAL    = 2'd1,
        PH_HOLD    = 2'd2,
        PH_RECOVER = 2'd3
    } phase_e;

    phase_e                         phase_q, phase_d;
    logic [STAGES-1:0][WIDTH-1:0]   data_q, data_d;
    logic [STAGES-1:0]              vld_q, vld_d;
    logic [WIDTH-1:0]               nor_res;
    logic                           capture;

    // Every stage moves on the same WAIT edge, so a word advances one stage per power-clock period.
    assign capture = (phase_q == PH_WAIT) && en;

    always_comb begin
        nor_res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nor_res[i] = ~(|in_data[i*FANIN +: FANIN]);
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (en) begin
            case (phase_q)
                PH_WAIT:    phase_d = PH_EVAL;
                PH_EVAL:    phase_d = PH_HOLD;
                PH_HOLD:    phase_d = PH_RECOVER;
                PH_RECOVER: phase_d = PH_WAIT;
                default:    phase_d = PH_WAIT;
            endcase
        end
    end

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (capture) begin
            // Stage 0 loads even for a bubble; its data is simply ignored downstream.
            data_d[0] = nor_res;
            vld_d[0]  = in_valid;
            for (int k = 1; k < STAGES; k++) begin
                data_d[k] = data_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_WAIT;
            data_q  <= '0;
            vld_q   <= '0;
        end else begin
            phase_q <= phase_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready  = capture;
    assign phase     = phase_q;
    assign out_valid = (phase_q == PH_HOLD) && vld_q[STAGES-1];

`ifdef ADIABATIC_RECOVERY_EN
    // Outside a valid HOLD the output charge is returned to the supply, so the bus reads zero.
    assign out = out_valid ? data_q[STAGES-1] : '0;
`else
    assign out = data_q[STAGES-1];
`endif

endmodule

// File: tb/tb_adiabatic_nor_pipe.sv
// Purpose : self-checking bench for adiabatic_nor_pipe (WIDTH=4, FANIN=2, STAGES=3).
// Latency : expected words carry an enabled-edge target and must appear exactly on it.
// Backpressure: none in the DUT; the bench captures only in WAIT cycles with en=1.
module tb_adiabatic_nor_pipe;

    localparam int WIDTH  = 4;
    localparam int FANIN  = 2;
    localparam int STAGES = 3;
    localparam int LAT    = 2 + 4*(STAGES-1);

    logic                   clk;
    logic                   reset;
    logic                   en;
    logic                   in_valid;
    logic [WIDTH*FANIN-1:0] in_data;
    logic                   in_ready;
    logic [1:0]             phase;
    logic                   out_valid;
    logic [WIDTH-1:0]       out;

    adiabatic_nor_pipe #(.WIDTH(WIDTH), .FANIN(FANIN), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .phase     (phase),
        .out_valid (out_valid),
        .out       (out)
    );

    typedef struct {
        logic [WIDTH-1:0] dat;
        int unsigned      tgt;
    } exp_t;

    exp_t        sb[$];
    int          obs[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int unsigned en_edges = 0;
    logic [1:0]  mdl_phase = 2'd0;
    logic        started  = 1'b0;
    logic        prev_vld = 1'b0;

    logic [WIDTH-1:0] out_hist   [64];
    logic [1:0]       phase_hist [64];
    logic             vld_hist   [64];
    logic             rdy_hist   [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Lane i is 1 only when both of its input bits are 0.
    function automatic logic [WIDTH-1:0] nor_lanes(input logic [WIDTH*FANIN-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (d[2*i] == 1'b0) && (d[2*i+1] == 1'b0);
        end
        return r;
    endfunction

    // Reference model: phase counter and capture scoreboard, updated on the DUT's edge.
    always @(posedge clk) begin
        if (reset) begin
            mdl_phase = 2'd0;
            sb.delete();
            cyc = 0;
        end else begin
            if (en) begin
                if (mdl_phase == 2'd0 && in_valid) begin
                    sb.push_back('{dat: nor_lanes(in_data), tgt: en_edges + LAT});
                end
                en_edges++;
                mdl_phase = mdl_phase + 2'd1;
            end
            cyc++;
        end
    end

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            if (cyc < 64) begin
                out_hist[cyc]   = out;
                phase_hist[cyc] = phase;
                vld_hist[cyc]   = out_valid;
                rdy_hist[cyc]   = in_ready;
            end
            check_eq("phase", {30'd0, phase}, {30'd0, mdl_phase});
            check_eq("in_ready", {31'd0, in_ready}, {31'd0, (mdl_phase == 2'd0) && en});
            if (sb.size() > 0 && en_edges > sb[0].tgt) begin
                check_eq("missing_output_edge", en_edges, sb[0].tgt);
                void'(sb.pop_front());
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    check_eq("out_data", {28'd0, out}, {28'd0, sb[0].dat});
                    check_eq("out_latency", en_edges, sb[0].tgt);
                    if (en && !reset) void'(sb.pop_front());
                end
            end
`ifdef ADIABATIC_RECOVERY_EN
            if (!out_valid) check_eq("recovered_zero", {28'd0, out}, 32'd0);
`endif
            if (out_valid && !prev_vld) obs.push_back(cyc);
            prev_vld = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: the first cycle after reset release.
    task automatic do_reset();
        reset    = 1'b1;
        en       = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        started = 1'b1;
        tick();
        reset = 1'b0;
        obs.delete();
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Single word, lanes 00/01/10/11 -> only lane 3 is 1.
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'b00_01_10_11;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        check_eq("rst_phase", {30'd0, phase_hist[0]}, 32'd0);
        check_eq("rst_in_ready", {31'd0, rdy_hist[0]}, 32'd1);
        check_eq("rst_out_valid", {31'd0, vld_hist[0]}, 32'd0);
        check_eq("rst_out", {28'd0, out_hist[0]}, 32'd0);
        check_eq("single_count", obs.size(), 32'd1);
        if (obs.size() > 0) check_eq("single_cycle", obs[0], 32'd10);
        check_eq("single_out", {28'd0, out_hist[10]}, 32'b1000);
        check_eq("single_vld9", {31'd0, vld_hist[9]}, 32'd0);
        check_eq("single_vld11", {31'd0, vld_hist[11]}, 32'd0);
`ifdef ADIABATIC_RECOVERY_EN
        check_eq("recov_out9", {28'd0, out_hist[9]}, 32'd0);
        check_eq("recov_out11", {28'd0, out_hist[11]}, 32'd0);
`else
        check_eq("plain_out9", {28'd0, out_hist[9]}, 32'b1000);
        check_eq("plain_out11", {28'd0, out_hist[11]}, 32'b1000);
`endif

        // Back-to-back words in consecutive WAIT slots.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            in_valid = (c == 0) || (c == 4);
            in_data  = (c == 0) ? 8'h00 : 8'hFF;
            tick();
        end
        in_valid = 1'b0;
        check_eq("b2b_count", obs.size(), 32'd2);
        if (obs.size() > 1) begin
            check_eq("b2b_cycle0", obs[0], 32'd10);
            check_eq("b2b_cycle1", obs[1], 32'd14);
        end
        check_eq("b2b_out10", {28'd0, out_hist[10]}, 32'hF);
        check_eq("b2b_out14", {28'd0, out_hist[14]}, 32'h0);

        // in_valid only outside WAIT: nothing may be captured.
        do_reset();
        for (int c = 0; c < 24; c++) begin
            in_valid = (c % 4) != 0;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (12) tick();
        check_eq("nonwait_count", obs.size(), 32'd0);

        // en low in cycles 5..7 stretches latency by three cycles.
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            en       = !((c >= 5) && (c <= 7));
            in_valid = (c == 0);
            in_data  = 8'h30;
            tick();
        end
        en       = 1'b1;
        in_valid = 1'b0;
        check_eq("stall_phase6", {30'd0, phase_hist[6]}, 32'd1);
        check_eq("stall_phase8", {30'd0, phase_hist[8]}, 32'd1);
        check_eq("stall_phase9", {30'd0, phase_hist[9]}, 32'd2);
        check_eq("stall_count", obs.size(), 32'd1);
        if (obs.size() > 0) check_eq("stall_cycle", obs[0], 32'd13);
        check_eq("stall_out13", {28'd0, out_hist[13]}, 32'b1011);

        // Reset in cycle 6 with two words in flight discards both.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0) || (c == 4);
            in_data  = 8'h00;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        repeat (21) tick();
        check_eq("midrst_phase", {30'd0, phase_hist[0]}, 32'd0);
        check_eq("midrst_count", obs.size(), 32'd0);

        // Random traffic with random en stalls; the monitor scores every output.
        do_reset();
        repeat (400) begin
            en       = $urandom_range(0, 3) != 0;
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = 8'($urandom);
            tick();
        end
        en       = 1'b1;
        in_valid = 1'b0;
        repeat (40) tick();
        check_eq("drain_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
